// File: rtl/spi_pkg.sv
// Shared SPI definitions for the serf (and the matching monarch).
package spi_pkg;

    localparam int unsigned SPI_WIDTH     = 16;
    localparam logic        SPI_SCLK_IDLE = 1'b1;

    typedef enum logic {SERF_IDLE, SERF_SHIFT} serf_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, plus one history flop
// for rise/fall detection in the clk domain.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= {STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = ~r_prev & o_sync;
    assign o_fall = r_prev & ~o_sync;

endmodule

// File: rtl/spi_serf.sv
// SPI responder: shifts in a WIDTH-bit command on MOSI while returning a
// word captured from tx_data at frame start. SCLK idles high.
module spi_serf
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = SPI_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rdy,
    output logic             frm_err,
    output logic             busy
);

    localparam int unsigned       CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(WIDTH + 1);

    serf_state_t        r_state, w_state_d;
    logic [WIDTH-1:0]   r_shift, w_shift_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [WIDTH-1:0]   r_rx, w_rx_d;
    logic               r_rdy, w_rdy_d;
    logic               r_err, w_err_d;
    logic [SYNC_STAGES:0] r_mosi_dly;
    logic [SYNC_STAGES:0] r_settle;

    logic w_ss_sync, w_ss_rise, w_ss_fall;
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_mosi_aligned, w_armed;
    logic w_unused_edges;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_ss_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (SS_n),
        .o_sync  (w_ss_sync),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SPI_SCLK_IDLE)
    ) u_sclk_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_async (SCLK),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    assign w_unused_edges = w_ss_sync ^ w_sclk_sync ^ w_sclk_fall;

    // One flop deeper than the SCLK sync so MOSI lines up with the SCLK prev flop.
    assign w_mosi_aligned = r_mosi_dly[SYNC_STAGES];

    // A select held low across reset shows up as a fall once the chain
    // flushes; edges are ignored until that flush has completed.
    assign w_armed = r_settle[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SERF_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_rx       <= '0;
            r_rdy      <= 1'b0;
            r_err      <= 1'b0;
            r_mosi_dly <= '0;
            r_settle   <= '0;
        end else begin
            r_state    <= w_state_d;
            r_shift    <= w_shift_d;
            r_cnt      <= w_cnt_d;
            r_rx       <= w_rx_d;
            r_rdy      <= w_rdy_d;
            r_err      <= w_err_d;
            r_mosi_dly <= {r_mosi_dly[SYNC_STAGES-1:0], MOSI};
            r_settle   <= {r_settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        w_rx_d    = r_rx;
        w_rdy_d   = 1'b0;
        w_err_d   = 1'b0;
        unique case (r_state)
            SERF_IDLE: begin
                if (w_ss_fall && w_armed) begin
                    w_shift_d = tx_data;
                    w_cnt_d   = '0;
                    w_state_d = SERF_SHIFT;
                end
            end
            SERF_SHIFT: begin
                if (w_sclk_rise) begin
                    w_shift_d = {r_shift[WIDTH-2:0], w_mosi_aligned};
                    if (r_cnt != CNT_SAT) begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                // Completion check sees this cycle's shift when both edges coincide.
                if (w_ss_rise) begin
                    w_state_d = SERF_IDLE;
                    if (w_cnt_d == CNT_FULL) begin
                        w_rx_d  = w_shift_d;
                        w_rdy_d = 1'b1;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            default: w_state_d = SERF_IDLE;
        endcase
    end

    assign MISO    = (r_state == SERF_SHIFT) ? r_shift[WIDTH-1] : 1'b0;
    assign busy    = (r_state == SERF_SHIFT);
    assign rx_data = r_rx;
    assign rdy     = r_rdy;
    assign frm_err = r_err;

endmodule

// File: tb/tb_spi_serf.sv
// Directed bench for spi_serf: a behavioural monarch (32-clk SCLK, idle high)
// drives frames; pulse counters watch rdy/frm_err.
module tb_spi_serf;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [15:0] tx_data;
    logic [15:0] rx_data;
    logic        rdy;
    logic        frm_err;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int n_rdy = 0;
    int n_frm = 0;

    logic [15:0] mon_resp;
    logic [15:0] mon_sh;

    spi_serf #(
        .WIDTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdy === 1'b1) n_rdy <= n_rdy + 1;
        if (frm_err === 1'b1) n_frm <= n_frm + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start(input logic [15:0] cmd);
        mon_sh   = cmd;
        mon_resp = '0;
        SS_n     = 1'b0;
        MOSI     = mon_sh[15];
        wait_clk(16);
    endtask

    // Monarch launches and samples one clk after each SCLK rise.
    task automatic clock_bits(input int n);
        for (int i = 0; i < n; i++) begin
            SCLK = 1'b0;
            wait_clk(16);
            SCLK = 1'b1;
            wait_clk(1);
            mon_resp = {mon_resp[14:0], MISO};
            mon_sh   = mon_sh << 1;
            MOSI     = mon_sh[15];
            wait_clk(15);
        end
    endtask

    task automatic frame_end();
        wait_clk(16);
        SS_n = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; tx_data = '0;
        wait_clk(3);
        n_vec++; if (rx_data !== 16'h0000) begin n_err++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
        n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        n_vec++; if (frm_err !== 1'b0) begin n_err++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", MISO); end
        rst = 1'b0;
        wait_clk(8);
    endtask

    task automatic test_single();
        int r0, f0;
        r0 = n_rdy; f0 = n_frm;
        tx_data = 16'h1234;
        frame_start(16'hA5C3);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
        clock_bits(16);
        wait_clk(16);
        SS_n = 1'b1;
        wait_clk(2);
        n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL single_rdy_early: got %b want 0", rdy); end
        wait_clk(1);
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy_latency: got %b want 1", rdy); end
        n_vec++; if (rx_data !== 16'hA5C3) begin n_err++; $display("FAIL single_rx: got %h want a5c3", rx_data); end
        wait_clk(29);
        n_vec++; if (n_rdy - r0 !== 1) begin n_err++; $display("FAIL single_rdy_count: got %0d want 1", n_rdy - r0); end
        n_vec++; if (n_frm - f0 !== 0) begin n_err++; $display("FAIL single_err_count: got %0d want 0", n_frm - f0); end
        n_vec++; if (mon_resp !== 16'h1234) begin n_err++; $display("FAIL single_resp: got %h want 1234", mon_resp); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int r0, f0;
        r0 = n_rdy; f0 = n_frm;
        tx_data = 16'hFFFF;
        frame_start(16'h0001);
        clock_bits(8);
        tx_data = 16'hDEAD;
        clock_bits(8);
        frame_end();
        wait_clk(32);
        n_vec++; if (rx_data !== 16'h0001) begin n_err++; $display("FAIL b2b_rx1: got %h want 0001", rx_data); end
        n_vec++; if (mon_resp !== 16'hFFFF) begin n_err++; $display("FAIL b2b_resp1: got %h want ffff", mon_resp); end
        tx_data = 16'h5A5A;
        frame_start(16'h8000);
        clock_bits(16);
        frame_end();
        wait_clk(32);
        n_vec++; if (rx_data !== 16'h8000) begin n_err++; $display("FAIL b2b_rx2: got %h want 8000", rx_data); end
        n_vec++; if (mon_resp !== 16'h5A5A) begin n_err++; $display("FAIL b2b_resp2: got %h want 5a5a", mon_resp); end
        n_vec++; if (n_rdy - r0 !== 2) begin n_err++; $display("FAIL b2b_rdy_count: got %0d want 2", n_rdy - r0); end
        n_vec++; if (n_frm - f0 !== 0) begin n_err++; $display("FAIL b2b_err_count: got %0d want 0", n_frm - f0); end
    endtask

    task automatic test_truncated();
        int r0, f0;
        r0 = n_rdy; f0 = n_frm;
        tx_data = 16'h0F0F;
        frame_start(16'hFFFF);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL trunc_busy: got %b want 1", busy); end
        clock_bits(7);
        frame_end();
        wait_clk(32);
        n_vec++; if (n_frm - f0 !== 1) begin n_err++; $display("FAIL trunc_err_count: got %0d want 1", n_frm - f0); end
        n_vec++; if (n_rdy - r0 !== 0) begin n_err++; $display("FAIL trunc_rdy_count: got %0d want 0", n_rdy - r0); end
        n_vec++; if (rx_data !== 16'h8000) begin n_err++; $display("FAIL trunc_rx: got %h want 8000", rx_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL trunc_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_idle_sclk();
        int r0, f0;
        r0 = n_rdy; f0 = n_frm;
        tx_data = 16'hC33C;
        for (int i = 0; i < 10; i++) begin
            SCLK = 1'b0;
            wait_clk(16);
            SCLK = 1'b1;
            wait_clk(16);
            n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL idle_miso[%0d]: got %b want 0", i, MISO); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy[%0d]: got %b want 0", i, busy); end
        end
        n_vec++; if (n_rdy - r0 !== 0 || n_frm - f0 !== 0) begin
            n_err++; $display("FAIL idle_pulses: got rdy %0d err %0d want 0 0", n_rdy - r0, n_frm - f0);
        end
        frame_start(16'h3C3C);
        clock_bits(16);
        frame_end();
        wait_clk(32);
        n_vec++; if (rx_data !== 16'h3C3C) begin n_err++; $display("FAIL idle_next_rx: got %h want 3c3c", rx_data); end
        n_vec++; if (mon_resp !== 16'hC33C) begin n_err++; $display("FAIL idle_next_resp: got %h want c33c", mon_resp); end
        n_vec++; if (n_rdy - r0 !== 1) begin n_err++; $display("FAIL idle_next_rdy: got %0d want 1", n_rdy - r0); end
    endtask

    task automatic test_reset_mid();
        int r0, f0;
        tx_data = 16'hAAAA;
        frame_start(16'h1234);
        clock_bits(8);
        SCLK = 1'b0;
        wait_clk(16);
        SCLK = 1'b1;
        wait_clk(1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        n_vec++; if (rx_data !== 16'h0000) begin n_err++; $display("FAIL rstmid_rx: got %h want 0000", rx_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rstmid_miso: got %b want 0", MISO); end
        n_vec++; if (rdy !== 1'b0 || frm_err !== 1'b0) begin
            n_err++; $display("FAIL rstmid_pulses: got rdy %b err %b want 0 0", rdy, frm_err);
        end
        r0 = n_rdy; f0 = n_frm;
        wait_clk(15);
        frame_end();
        wait_clk(32);
        n_vec++; if (n_rdy - r0 !== 0 || n_frm - f0 !== 0) begin
            n_err++; $display("FAIL rstmid_ss_rise: got rdy %0d err %0d want 0 0", n_rdy - r0, n_frm - f0);
        end
        n_vec++; if (rx_data !== 16'h0000) begin n_err++; $display("FAIL rstmid_rx_hold: got %h want 0000", rx_data); end
        tx_data = 16'h0F0F;
        frame_start(16'h7E81);
        clock_bits(16);
        frame_end();
        wait_clk(32);
        n_vec++; if (rx_data !== 16'h7E81) begin n_err++; $display("FAIL rstmid_next_rx: got %h want 7e81", rx_data); end
        n_vec++; if (mon_resp !== 16'h0F0F) begin n_err++; $display("FAIL rstmid_next_resp: got %h want 0f0f", mon_resp); end
        n_vec++; if (n_rdy - r0 !== 1) begin n_err++; $display("FAIL rstmid_next_rdy: got %0d want 1", n_rdy - r0); end
    endtask

    task automatic test_overrun();
        int r0, f0;
        r0 = n_rdy; f0 = n_frm;
        tx_data = 16'h1111;
        frame_start(16'hBEEF);
        clock_bits(17);
        frame_end();
        wait_clk(32);
        n_vec++; if (n_frm - f0 !== 1) begin n_err++; $display("FAIL over_err_count: got %0d want 1", n_frm - f0); end
        n_vec++; if (n_rdy - r0 !== 0) begin n_err++; $display("FAIL over_rdy_count: got %0d want 0", n_rdy - r0); end
        n_vec++; if (rx_data !== 16'h7E81) begin n_err++; $display("FAIL over_rx: got %h want 7e81", rx_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_truncated();
        test_idle_sclk();
        test_reset_mid();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
